// File: rtl/alu_ctrl_seq_pkg.sv
// Shared constants for the EX-stage ALU-control sequencer: ALU codes, ALUOp and
// funct encodings, and the FSM state type.
package alu_ctrl_seq_pkg;

    // ALU operation codes (NOP is all-ones at whatever CTRL_W is in use)
    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_AND = 2;
    localparam int unsigned ALU_OR  = 3;
    localparam int unsigned ALU_SLT = 4;
    localparam int unsigned ALU_MUL = 5;
    localparam int unsigned ALU_DIV = 6;

    // ALUOp from main control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    // R-type funct field
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OUT   = 2'd1,
        S_MULTI = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational ALU-control decode.
// Ports: alu_op/funct in; code (CTRL_W), multi (MUL/DIV), illegal (undefined funct) out.
module alu_ctrl_seq_decode
    import alu_ctrl_seq_pkg::*;
#(
    parameter int unsigned CTRL_W = 4
) (
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] code,
    output logic              multi,
    output logic              illegal
);

    always_comb begin
        code    = {CTRL_W{1'b1}};
        multi   = 1'b0;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: code = CTRL_W'(ALU_ADD);
            ALUOP_SUB: code = CTRL_W'(ALU_SUB);
            ALUOP_SLT: code = CTRL_W'(ALU_SLT);
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: code = CTRL_W'(ALU_ADD);
                    FUNCT_SUB: code = CTRL_W'(ALU_SUB);
                    FUNCT_AND: code = CTRL_W'(ALU_AND);
                    FUNCT_OR:  code = CTRL_W'(ALU_OR);
                    FUNCT_SLT: code = CTRL_W'(ALU_SLT);
                    FUNCT_MUL: begin
                        code  = CTRL_W'(ALU_MUL);
                        multi = 1'b1;
                    end
                    FUNCT_DIV: begin
                        code  = CTRL_W'(ALU_DIV);
                        multi = 1'b1;
                    end
                    default:   illegal = 1'b1;
                endcase
            end
            default: code = {CTRL_W{1'b1}};
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU-control decoder with MUL/DIV latency sequencing.
// Ports: clk, rst (async, active-high); in_valid/in_ready, alu_op, funct (producer side);
// out_valid/out_ready, alu_ctrl, multi, illegal (consumer side); busy (stall request).
module alu_ctrl_seq
    import alu_ctrl_seq_pkg::*;
#(
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              multi,
    output logic              illegal,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_d, multi_d, illegal_d, busy_d;
    logic [CTRL_W-1:0] alu_ctrl_d;

    logic [CTRL_W-1:0] dec_code;
    logic              dec_multi, dec_illegal;
    logic              accept, dec_is_mul, dec_long;
    logic [CNT_W-1:0]  dec_cnt;

    alu_ctrl_seq_decode #(.CTRL_W(CTRL_W)) u_decode (
        .alu_op  (alu_op),
        .funct   (funct),
        .code    (dec_code),
        .multi   (dec_multi),
        .illegal (dec_illegal)
    );

    // Ready while empty, or while the held code is being consumed this cycle
    assign in_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_OUT) && out_ready));
    assign accept   = in_valid && in_ready;

    // Latency selection; a latency of 1 behaves like a single-cycle op
    assign dec_is_mul = (dec_code == CTRL_W'(ALU_MUL));
    assign dec_long   = dec_multi && (dec_is_mul ? (MUL_CYCLES > 1) : (DIV_CYCLES > 1));
    assign dec_cnt    = dec_is_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            alu_ctrl  <= {CTRL_W{1'b1}};
            multi     <= 1'b0;
            illegal   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_valid <= out_valid_d;
            alu_ctrl  <= alu_ctrl_d;
            multi     <= multi_d;
            illegal   <= illegal_d;
            busy      <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid;
        alu_ctrl_d  = alu_ctrl;
        multi_d     = multi;
        illegal_d   = illegal;
        busy_d      = busy;
        case (state_q)
            S_IDLE, S_OUT: begin
                if (accept) begin
                    alu_ctrl_d = dec_code;
                    multi_d    = dec_multi;
                    illegal_d  = dec_illegal;
                    if (dec_long) begin
                        state_d     = S_MULTI;
                        cnt_d       = dec_cnt;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b1;
                    end else begin
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end else if ((state_q == S_OUT) && out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            S_MULTI: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = S_OUT;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

    localparam int unsigned CTRL_W     = 4;
    localparam int unsigned MUL_CYCLES = 4;
    localparam int unsigned DIV_CYCLES = 8;
    localparam int unsigned CNT_W      = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              multi, illegal, busy;

    always #5 clk = ~clk;

    alu_ctrl_seq #(
        .CTRL_W(CTRL_W), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .multi(multi), .illegal(illegal), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level reference: one held item with cycles remaining until valid
    bit m_have;
    int m_remain;
    int m_code;
    bit m_multi, m_illegal;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        int         code;
        bit         mu;
        bit         il;
        int         lat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                       output int code, output bit mu, output bit il,
                                       output int lat);
        mu = 0; il = 0; lat = 1; code = 15;
        if (op == 2'b00)      code = 0;
        else if (op == 2'b01) code = 1;
        else if (op == 2'b11) code = 4;
        else begin
            case (fn)
                6'h20: code = 0;
                6'h22: code = 1;
                6'h24: code = 2;
                6'h25: code = 3;
                6'h2a: code = 4;
                6'h18: begin code = 5; mu = 1; lat = MUL_CYCLES; end
                6'h1a: begin code = 6; mu = 1; lat = DIV_CYCLES; end
                default: begin code = 15; il = 1; end
            endcase
        end
    endfunction

    task automatic model_reset();
        m_have = 0; m_remain = 0; m_code = 15; m_multi = 0; m_illegal = 0;
    endtask

    function automatic bit m_ready();
        return !rst && (!m_have || (m_remain == 0 && out_ready));
    endfunction

    task automatic check_regs();
        chk("out_valid", 32'(out_valid), 32'(m_have && m_remain == 0));
        chk("busy",      32'(busy),      32'(m_have && m_remain > 0));
        chk("alu_ctrl",  32'(alu_ctrl),  32'(m_code));
        chk("multi",     32'(multi),     32'(m_multi));
        chk("illegal",   32'(illegal),   32'(m_illegal));
    endtask

    // One clock: check ready, advance model at the edge, check registered outputs
    task automatic step();
        bit acc;
        int c, lat;
        bit mu, il;
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        acc = in_valid && m_ready();
        c = 0; lat = 1; mu = 0; il = 0;
        if (acc) ref_decode(alu_op, funct, c, mu, il, lat);
        @(posedge clk);
        if (rst) model_reset();
        else if (acc) begin
            m_have = 1; m_remain = lat - 1; m_code = c; m_multi = mu; m_illegal = il;
        end else if (m_have && m_remain > 0) m_remain--;
        else if (m_have && out_ready) m_have = 0;
        #1;
        check_regs();
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 0; out_ready = 1;
        while (m_have && n < 40) begin step(); n++; end
        chk("drain_timeout", 32'(m_have), 32'(0));
    endtask

    task automatic async_reset_check(input string tag);
        rst = 1;
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_alu_ctrl"},  32'(alu_ctrl),  32'(4'hF));
        chk({tag, "_busy"},      32'(busy),      32'(0));
        chk({tag, "_illegal"},   32'(illegal),   32'(0));
        model_reset();
        in_valid = 0;
        @(negedge clk);
        rst = 0;
        step();
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'(1));
    endtask

    logic [1:0] s_op [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10};
    logic [5:0] s_fn [6] = '{6'h00, 6'h00, 6'h00, 6'h20, 6'h22, 6'h2a};
    int         s_ex [6] = '{0, 1, 4, 0, 1, 4};
    logic [5:0] fn_pool [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h18, 6'h1a, 6'h3f};

    initial begin
        tbl[0]  = '{2'b00, 6'h00, 0,  0, 0, 1};
        tbl[1]  = '{2'b01, 6'h00, 1,  0, 0, 1};
        tbl[2]  = '{2'b11, 6'h00, 4,  0, 0, 1};
        tbl[3]  = '{2'b10, 6'h20, 0,  0, 0, 1};
        tbl[4]  = '{2'b10, 6'h22, 1,  0, 0, 1};
        tbl[5]  = '{2'b10, 6'h24, 2,  0, 0, 1};
        tbl[6]  = '{2'b10, 6'h25, 3,  0, 0, 1};
        tbl[7]  = '{2'b10, 6'h2a, 4,  0, 0, 1};
        tbl[8]  = '{2'b10, 6'h18, 5,  1, 0, 4};
        tbl[9]  = '{2'b10, 6'h1a, 6,  1, 0, 8};
        tbl[10] = '{2'b10, 6'h3f, 15, 0, 1, 1};
        tbl[11] = '{2'b10, 6'h00, 15, 0, 1, 1};

        rst = 1; in_valid = 0; out_ready = 1; alu_op = 0; funct = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        rst = 0;
        step();
        chk("in_ready_after_reset", 32'(in_ready), 32'(1));

        // Full-rate stream of single-cycle ops
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; alu_op = s_op[i]; funct = s_fn[i];
            step();
            chk("stream_code",  32'(alu_ctrl),  32'(s_ex[i]));
            chk("stream_valid", 32'(out_valid), 32'(1));
        end
        drain();

        // Decode table with latency and busy-cycle count
        for (int i = 0; i < 12; i++) begin
            int n, nb;
            drain();
            in_valid = 1; alu_op = tbl[i].op; funct = tbl[i].fn;
            step();
            in_valid = 0;
            n = 1; nb = 0;
            while (!out_valid && n < 20) begin
                if (busy) nb++;
                chk("busy_blocks_ready", 32'(in_ready), 32'(0));
                step(); n++;
            end
            chk("tbl_latency", 32'(n),        32'(tbl[i].lat));
            chk("tbl_busy",    32'(nb),       32'(tbl[i].lat - 1));
            chk("tbl_code",    32'(alu_ctrl), 32'(tbl[i].code));
            chk("tbl_multi",   32'(multi),    32'(tbl[i].mu));
            chk("tbl_illegal", 32'(illegal),  32'(tbl[i].il));
        end
        drain();

        // Backpressure holds the code; pending op accepted on the releasing edge
        in_valid = 1; alu_op = 2'b01; funct = 0;
        step();
        out_ready = 0; alu_op = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'(0));
            step();
            chk("bp_code_held", 32'(alu_ctrl),  32'(1));
            chk("bp_valid",     32'(out_valid), 32'(1));
        end
        out_ready = 1;
        step();
        chk("bp_release_code", 32'(alu_ctrl), 32'(4));
        drain();

        // Mid-stream async reset while a single-cycle result is held
        in_valid = 1; alu_op = 2'b10; funct = 6'h3f;
        step();
        async_reset_check("rst_stream");

        // Reset while DIV is in flight: no code 6 may ever appear
        in_valid = 1; alu_op = 2'b10; funct = 6'h1a;
        step();
        in_valid = 0;
        repeat (3) step();
        async_reset_check("rst_div");
        for (int i = 0; i < 10; i++) begin
            step();
            chk("no_div_after_abort", 32'(alu_ctrl == 4'd6 || out_valid), 32'(0));
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            alu_op    = 2'($urandom_range(0, 3));
            funct     = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                    : fn_pool[$urandom_range(0, 7)];
            rst       = ($urandom_range(0, 199) == 0);
            step();
            rst = 0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
